// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, ALU-op, special-register and control-bundle definitions shared by the CPU pipeline.
package cpu_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_MOV, OP_MOV_TO_ADR, OP_MOV_FROM_ADR, OP_LDI_ADR, OP_LDI_MATH,
    OP_MOV_FROM_MATH, OP_MOV_TO_MATH, OP_MOV_MATH_ADR, OP_QMOV_FROM_MATH, OP_QMOV_TO_CNT,
    OP_MOV_FROM_CNT, OP_MOV_TO_CNT, OP_LDI_CNT, OP_BE, OP_BNE, OP_BEZ, OP_BLTZ, OP_BGTE,
    OP_EVU, OP_EVL, OP_LD, OP_ST, OP_JMP, OP_LDI, OP_HALT
  } opcode_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_EVU = 4'd2, ALU_EVL = 4'd3,
                         ALU_GTE = 4'd4, ALU_LTZ = 4'd5, ALU_EZ = 4'd6, ALU_EQ = 4'd7, ALU_NE = 4'd8;
  // Register fields are carried at the widest supported address width and narrowed at the stage output.
  localparam int REG_AW_MAX = 8;
  typedef logic [REG_AW_MAX-1:0] reg_addr_t;
  localparam reg_addr_t REG_ADR = 4, REG_MATH = 5, REG_CNT = 7;
  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
  typedef struct packed {
    reg_addr_t  rs0;
    reg_addr_t  rs1;
    reg_addr_t  wr;
    logic       we;
    logic       move;
    logic       imm;
    logic       mem2reg;
    logic       memwr;
    logic       branch;
    logic       start;
    logic       jump_sign;
    logic [3:0] aluop;
    logic [1:0] quarter;
    logic [1:0] reg2mem;
  } ctrl_bundle_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/execute handshake and decoded control outputs of decode_stage.
// instr_count/branch_count exist only when DECODE_PERF_CNT_EN is defined.
interface decode_stage_if #(
  parameter int INSTR_W = 9,
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 32
);
  logic               in_valid, in_ready, flush, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [REG_AW-1:0]  out_rs0, out_rs1, out_wr;
  logic               out_we, out_move, out_imm, out_mem2reg, out_memwr, out_branch, out_start, out_jump_sign;
  logic [3:0]         out_aluop;
  logic [1:0]         out_quarter, out_reg2mem;
  logic               halted, illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0]   instr_count, branch_count;
`else
  logic               unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_rs0, out_rs1, out_wr, out_we, out_move, out_imm, out_mem2reg,
           out_memwr, out_branch, out_start, out_jump_sign, out_aluop, out_quarter, out_reg2mem,
           halted, illegal
`ifdef DECODE_PERF_CNT_EN
    , instr_count, branch_count
`endif
  );
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_rs0, out_rs1, out_wr, out_we, out_move, out_imm, out_mem2reg,
           out_memwr, out_branch, out_start, out_jump_sign, out_aluop, out_quarter, out_reg2mem,
           halted, illegal
`ifdef DECODE_PERF_CNT_EN
    , instr_count, branch_count
`endif
  );
endinterface

// File: rtl/decode_lut.sv
// decode_lut: combinational instruction-word to control-bundle decoder; undefined opcodes give a zero bundle plus illegal.
module decode_lut
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int OPC_W   = 5
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_bundle_t       ctrl,
  output logic               illegal
);
  localparam int OPR_W = INSTR_W - OPC_W;
  logic [OPC_W-1:0] opc;
  logic [OPR_W-1:0] opr;
  reg_addr_t        hi, lo, full;
  assign opc     = instr[INSTR_W-1 -: OPC_W];
  assign opr     = instr[OPR_W-1:0];
  assign hi      = reg_addr_t'(opr[3:2]);
  assign lo      = reg_addr_t'(opr[1:0]);
  assign full    = reg_addr_t'(opr);
  assign illegal = 32'(opc) > 32'(OP_HALT);
  always_comb begin
    ctrl = '0;
    if (!illegal)
      case (opcode_t'(opc[4:0]))
        OP_ADD, OP_SUB:    begin ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = REG_MATH; ctrl.wr = lo; ctrl.aluop = opc[0] ? ALU_SUB : ALU_ADD; end
        OP_MOV:            begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = lo; end
        OP_MOV_TO_ADR:     begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = REG_ADR; end
        OP_MOV_FROM_ADR:   begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = REG_ADR; ctrl.wr = lo; end
        OP_MOV_FROM_MATH:  begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = REG_MATH; ctrl.wr = lo; end
        OP_MOV_TO_MATH:    begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = REG_MATH; end
        OP_MOV_MATH_ADR:   begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = REG_MATH; ctrl.wr = REG_ADR; ctrl.quarter = opr[3:2]; end
        OP_QMOV_FROM_MATH: begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = REG_MATH; ctrl.wr = lo; ctrl.quarter = opr[3:2]; end
        OP_QMOV_TO_CNT:    begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = lo; ctrl.wr = REG_CNT; ctrl.quarter = opr[3:2]; end
        OP_MOV_FROM_CNT:   begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = REG_CNT; ctrl.wr = lo; end
        OP_MOV_TO_CNT:     begin ctrl.move = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = REG_CNT; end
        OP_LDI_ADR:        begin ctrl.imm = 1'b1; ctrl.we = 1'b1; ctrl.wr = REG_ADR; ctrl.jump_sign = opr[0]; end
        OP_LDI_MATH:       begin ctrl.imm = 1'b1; ctrl.we = 1'b1; ctrl.rs0 = full; ctrl.wr = REG_MATH; end
        OP_LDI_CNT:        begin ctrl.imm = 1'b1; ctrl.we = 1'b1; ctrl.wr = REG_CNT; end
        OP_LDI:            begin ctrl.imm = 1'b1; ctrl.we = 1'b1; ctrl.wr = lo; end
        OP_BE:             begin ctrl.branch = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = lo; ctrl.aluop = ALU_EQ; end
        OP_BNE:            begin ctrl.branch = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = lo; ctrl.aluop = ALU_NE; end
        OP_BEZ:            begin ctrl.branch = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = lo; ctrl.aluop = ALU_EZ; end
        OP_BLTZ:           begin ctrl.branch = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = lo; ctrl.aluop = ALU_LTZ; end
        OP_BGTE:           begin ctrl.branch = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = lo; ctrl.aluop = ALU_GTE; end
        OP_JMP:            begin ctrl.branch = 1'b1; ctrl.aluop = ALU_EQ; end
        OP_EVU:            begin ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = lo; ctrl.aluop = ALU_EVU; end
        OP_EVL:            begin ctrl.we = 1'b1; ctrl.rs0 = hi; ctrl.wr = lo; ctrl.aluop = ALU_EVL; end
        OP_LD:             begin ctrl.we = 1'b1; ctrl.mem2reg = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = REG_ADR; ctrl.wr = lo; end
        OP_ST:             begin ctrl.memwr = 1'b1; ctrl.rs0 = hi; ctrl.rs1 = REG_ADR; ctrl.reg2mem = opr[1:0]; end
        OP_HALT:           ctrl.start = 1'b1;
        default:           ctrl = '0;
      endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready handshake, branch flush and halt drain FSM.
// Define DECODE_PERF_CNT_EN to add the instr_count/branch_count performance counters.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int OPC_W   = 5,
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  state_t       state, state_nxt;
  ctrl_bundle_t dec, q;
  logic         dec_ill, valid, ill, kill, accept, done;
  logic         unused_hi;
  decode_lut #(.INSTR_W(INSTR_W), .OPC_W(OPC_W)) u_lut (.instr(bus.in_instr), .ctrl(dec), .illegal(dec_ill));
  // Flush is ignored once halted; elsewhere it overrides both accept and completion.
  assign kill         = bus.flush & (state != HALTED);
  assign bus.in_ready = (state != HALTED) & (state != HALT_PEND) & (~valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready & ~kill;
  assign done         = valid & bus.out_ready & ~kill;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      valid <= 1'b0;
      q     <= '0;
      ill   <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= ~kill & (accept | (valid & ~bus.out_ready));
      q     <= kill ? '0 : accept ? dec : done ? '0 : q;
      ill   <= accept & dec_ill;
    end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN)       ? ((accept & dec.start) ? HALT_PEND : RUN) :
                (state == HALT_PEND) ? (kill ? RUN : done ? HALTED : HALT_PEND) : HALTED;
  end
  assign bus.out_valid     = valid;
  assign bus.illegal       = ill;
  assign bus.halted        = state == HALTED;
  assign bus.out_rs0       = q.rs0[REG_AW-1:0];
  assign bus.out_rs1       = q.rs1[REG_AW-1:0];
  assign bus.out_wr        = q.wr[REG_AW-1:0];
  assign bus.out_we        = q.we;
  assign bus.out_move      = q.move;
  assign bus.out_imm       = q.imm;
  assign bus.out_mem2reg   = q.mem2reg;
  assign bus.out_memwr     = q.memwr;
  assign bus.out_branch    = q.branch;
  assign bus.out_start     = q.start;
  assign bus.out_jump_sign = q.jump_sign;
  assign bus.out_aluop     = q.aluop;
  assign bus.out_quarter   = q.quarter;
  assign bus.out_reg2mem   = q.reg2mem;
  assign unused_hi = ^{q.rs0[REG_AW_MAX-1:REG_AW], q.rs1[REG_AW_MAX-1:REG_AW], q.wr[REG_AW_MAX-1:REG_AW]};
`ifdef DECODE_PERF_CNT_EN
  logic             held_ill;
  logic [CNT_W-1:0] instr_cnt, branch_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held_ill   <= 1'b0;
      instr_cnt  <= '0;
      branch_cnt <= '0;
    end else begin
      if (accept) held_ill <= dec_ill;
      if (done & ~held_ill) instr_cnt <= instr_cnt + CNT_W'(1);
      if (done & q.branch) branch_cnt <= branch_cnt + CNT_W'(1);
    end
  assign bus.instr_count  = instr_cnt;
  assign bus.branch_count = branch_cnt;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized bench for decode_stage against a table-driven reference decoder.
module tb_decode_stage;
  localparam int IW = 9, OW = 5, AW = 4, CW = 32;
  logic clk = 1'b0, rst_n = 1'b1;
  int vectors = 0, miscompares = 0;
  logic [27:0] got;
  logic exp_valid, exp_ill, exp_held_ill;
  logic [27:0] exp_b;
  logic [CW-1:0] exp_ic, exp_bc;
  // Per-opcode operand sources: 0 none, 1 op[3:2], 2 op[1:0], 3 ADR, 4 MATH, 5 CNT, 6 whole operand.
  int rs0_t [27] = '{1,1,1,1,3,0,6,4,1,4,4,2,5,1,0,1,1,1,1,1,1,1,1,1,0,0,0};
  int rs1_t [27] = '{4,4,0,0,0,0,0,0,0,0,0,0,0,0,0,2,2,2,2,2,0,0,3,3,0,0,0};
  int wr_t  [27] = '{2,2,2,3,2,3,4,2,4,3,2,5,2,5,5,0,0,0,0,0,2,2,2,0,0,2,0};
  int alu_t [27] = '{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,7,8,6,5,4,2,3,0,0,7,0,0};
  decode_stage_if #(.INSTR_W(IW), .REG_AW(AW), .CNT_W(CW)) bus();
  decode_stage #(.INSTR_W(IW), .OPC_W(OW), .REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.out_rs0, bus.out_rs1, bus.out_wr, bus.out_we, bus.out_move, bus.out_imm, bus.out_mem2reg,
                bus.out_memwr, bus.out_branch, bus.out_start, bus.out_jump_sign, bus.out_aluop, bus.out_quarter,
                bus.out_reg2mem};

  function automatic logic [3:0] pick(input int code, input logic [3:0] r);
    logic [3:0] v [7];
    v = '{4'd0, {2'b0, r[3:2]}, {2'b0, r[1:0]}, 4'd4, 4'd5, 4'd7, r};
    return v[code];
  endfunction

  function automatic logic [27:0] model(input logic [8:0] ins);
    int op;
    logic [3:0] r;
    logic we, mv, im, m2r, mw, br, st, js;
    logic [1:0] qs, r2m;
    op = int'(ins[8:4]);
    r = ins[3:0];
    if (op > 26) return '0;
    we  = op inside {[0:14], [20:22], 25};
    mv  = op inside {[2:4], [7:13]};
    im  = op inside {5, 6, 14, 25};
    br  = op inside {[15:19], 24};
    m2r = op == 22;
    mw  = op == 23;
    st  = op == 26;
    js  = op == 5 && r[0];
    qs  = (op inside {[9:11]}) ? r[3:2] : 2'd0;
    r2m = mw ? r[1:0] : 2'd0;
    return {pick(rs0_t[op], r), pick(rs1_t[op], r), pick(wr_t[op], r), we, mv, im, m2r, mw, br, st, js,
            4'(alu_t[op]), qs, r2m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.in_instr = '0; bus.flush = 0; bus.out_ready = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    exp_valid = 0; exp_ill = 0; exp_held_ill = 0; exp_b = '0; exp_ic = '0; exp_bc = '0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_instr = '0; bus.flush = 0; bus.out_ready = 0;
    #1 rst_n = 0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hold_valid got %b want 0", bus.out_valid); end
    tick();
    rst_n = 1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
    vectors++; if (got !== 28'd0) begin miscompares++; $display("FAIL reset_bundle got %h want 0", got); end
`ifdef DECODE_PERF_CNT_EN
    vectors++; if (bus.instr_count !== '0 || bus.branch_count !== '0) begin miscompares++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus.instr_count, bus.branch_count); end
`endif
  endtask

  task automatic test_add();
    bus.in_valid = 1; bus.in_instr = 9'b00000_1001; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_rs0 !== 4'd2) begin miscompares++; $display("FAIL add_rs0 got %0d want 2", bus.out_rs0); end
    vectors++; if (bus.out_rs1 !== 4'd5) begin miscompares++; $display("FAIL add_rs1 got %0d want 5", bus.out_rs1); end
    vectors++; if (bus.out_wr !== 4'd1) begin miscompares++; $display("FAIL add_wr got %0d want 1", bus.out_wr); end
    vectors++; if (bus.out_we !== 1'b1) begin miscompares++; $display("FAIL add_we got %b want 1", bus.out_we); end
    vectors++; if (bus.out_aluop !== 4'd0) begin miscompares++; $display("FAIL add_aluop got %0d want 0", bus.out_aluop); end
    vectors++; if (got !== model(9'b00000_1001)) begin miscompares++; $display("FAIL add_bundle got %h want %h", got, model(9'b00000_1001)); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random(input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      logic v, rdy, fl, acc, want_rdy;
      logic [8:0] ins;
      v = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 15) == 0;
      ins = {5'($urandom_range(0, 31)), 4'($urandom)};
      if (ins[8:4] == 5'd26) ins[8:4] = 5'd2;
      bus.in_valid = v; bus.in_instr = ins; bus.out_ready = rdy; bus.flush = fl;
      #1;
      want_rdy = !exp_valid || rdy;
      vectors++; if (bus.in_ready !== want_rdy) begin miscompares++; $display("FAIL rand_in_ready[%0d] got %b want %b", i, bus.in_ready, want_rdy); end
      acc = v && want_rdy && !fl;
      @(posedge clk);
      if (exp_valid && rdy && !fl) begin
        if (!exp_held_ill) exp_ic++;
        if (exp_b[10]) exp_bc++;
      end
      exp_ill = acc && ins[8:4] > 5'd26;
      if (fl) exp_valid = 0;
      else if (acc) begin exp_valid = 1; exp_b = model(ins); exp_held_ill = ins[8:4] > 5'd26; end
      else if (rdy) exp_valid = 0;
      #1;
      vectors++; if (bus.out_valid !== exp_valid) begin miscompares++; $display("FAIL rand_valid[%0d] instr %b got %b want %b", i, ins, bus.out_valid, exp_valid); end
      vectors++; if (bus.illegal !== exp_ill) begin miscompares++; $display("FAIL rand_illegal[%0d] instr %b got %b want %b", i, ins, bus.illegal, exp_ill); end
      if (exp_valid) begin
        vectors++; if (got !== exp_b) begin miscompares++; $display("FAIL rand_bundle[%0d] instr %b got %h want %h", i, ins, got, exp_b); end
      end
`ifdef DECODE_PERF_CNT_EN
      vectors++; if (bus.instr_count !== exp_ic || bus.branch_count !== exp_bc) begin miscompares++; $display("FAIL rand_counters[%0d] got %0d/%0d want %0d/%0d", i, bus.instr_count, bus.branch_count, exp_ic, exp_bc); end
`endif
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    tick();
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1; bus.in_instr = 9'b10111_1110; bus.out_ready = 0;
    tick();
    bus.in_instr = 9'b00000_0110;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      vectors++; if (bus.out_memwr !== 1'b1 || bus.out_rs1 !== 4'd4 || bus.out_reg2mem !== 2'd2) begin miscompares++; $display("FAIL bp_fields[%0d] got memwr %b rs1 %0d reg2mem %0d want 1 4 2", i, bus.out_memwr, bus.out_rs1, bus.out_reg2mem); end
      vectors++; if (got !== model(9'b10111_1110)) begin miscompares++; $display("FAIL bp_bundle[%0d] got %h want %h", i, got, model(9'b10111_1110)); end
      tick();
    end
    bus.in_valid = 0; bus.out_ready = 1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    bus.in_valid = 1; bus.in_instr = {5'd27, 4'hf}; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL ill_pulse got %b want 1", bus.illegal); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL ill_valid got %b want 1", bus.out_valid); end
    vectors++; if (got !== 28'd0) begin miscompares++; $display("FAIL ill_bundle got %h want 0", got); end
    tick();
    vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL ill_pulse_end got %b want 0", bus.illegal); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] seq [7];
    do_reset();
    for (int i = 0; i < 4; i++) seq[i] = {5'd0, 4'($urandom)};
    for (int i = 4; i < 6; i++) seq[i] = {5'd15, 4'($urandom)};
    seq[6] = {5'($urandom_range(27, 31)), 4'($urandom)};
    bus.out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1; bus.in_instr = seq[i];
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1 || got !== model(seq[i])) begin miscompares++; $display("FAIL b2b_bundle[%0d] got v%b %h want v1 %h", i, bus.out_valid, got, model(seq[i])); end
    end
    bus.in_valid = 0;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
`ifdef DECODE_PERF_CNT_EN
    vectors++; if (bus.instr_count !== 32'd6) begin miscompares++; $display("FAIL perf_instr_count got %0d want 6", bus.instr_count); end
    vectors++; if (bus.branch_count !== 32'd2) begin miscompares++; $display("FAIL perf_branch_count got %0d want 2", bus.branch_count); end
`endif
  endtask

  task automatic test_flush_halt();
    bus.in_valid = 1; bus.in_instr = 9'b11010_0000; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1 || got !== model(9'b11010_0000)) begin miscompares++; $display("FAIL fh_bundle got v%b %h want v1 %h", bus.out_valid, got, model(9'b11010_0000)); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fh_pend_ready got %b want 0", bus.in_ready); end
    tick();
    vectors++; if (bus.in_ready !== 1'b0 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL fh_pend_hold got rdy %b halted %b want 0 0", bus.in_ready, bus.halted); end
    bus.flush = 1; bus.in_valid = 1; bus.in_instr = 9'b00001_0111;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fh_flush_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL fh_back_to_run got rdy %b halted %b want 1 0", bus.in_ready, bus.halted); end
    bus.in_valid = 1; bus.in_instr = 9'b00001_0111;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1 || got !== model(9'b00001_0111)) begin miscompares++; $display("FAIL fh_next_accept got v%b %h want v1 %h", bus.out_valid, got, model(9'b00001_0111)); end
    bus.out_ready = 1;
    tick();
  endtask

  task automatic test_halt();
    bus.in_valid = 1; bus.in_instr = 9'b11010_0000; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.in_ready !== 1'b0 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL halt_pend got rdy %b halted %b want 0 0", bus.in_ready, bus.halted); end
    bus.out_ready = 1;
    tick();
    vectors++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_enter got halted %b valid %b want 1 0", bus.halted, bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1; bus.in_instr = {5'($urandom_range(0, 25)), 4'($urandom)}; bus.flush = 1'($urandom);
      #1;
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL halted_ready[%0d] got %b want 0", i, bus.in_ready); end
      @(posedge clk); #1;
      vectors++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL halted_stay[%0d] got halted %b valid %b want 1 0", i, bus.halted, bus.out_valid); end
    end
    bus.in_valid = 0; bus.flush = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.in_valid = 1; bus.in_instr = 9'b10100_1011; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre got %b want 1", bus.out_valid); end
    #1 rst_n = 0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || got !== 28'd0) begin miscompares++; $display("FAIL areset_clear got v%b %h want v0 0", bus.out_valid, got); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL areset_state got rdy %b halted %b want 1 0", bus.in_ready, bus.halted); end
    #2 rst_n = 1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_after got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_random(300);
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_flush_halt();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage for the pipelined CPU. Sits between fetch and register-read/execute. Turns each accepted instruction word into a registered control bundle behind a valid/ready handshake. Adds branch flush, a halt drain state machine, illegal-opcode flagging and optional performance counters.

## Interface
- `INSTR_W`, default 9: instruction width. Opcode is the top `OPC_W` bits; the remaining `OPR_W = INSTR_W-OPC_W` bits are the operand.
- `OPC_W`, default 5: opcode width.
- `REG_AW`, default 4: register-address width. Must be ≥3.
- `CNT_W`, default 32: performance-counter width.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `in_valid` in 1, `in_ready` out 1, `in_instr` in INSTR_W: fetch handshake.
- `flush` in 1: taken branch from execute. Kills the held bundle and any same-cycle accept.
- `out_valid` out 1, `out_ready` in 1: execute handshake.
- `out_rs0`, `out_rs1`, `out_wr` out REG_AW: read and write register addresses.
- `out_we`, `out_move`, `out_imm`, `out_mem2reg`, `out_memwr`, `out_branch`, `out_start`, `out_jump_sign` out 1: control strobes.
- `out_aluop` out 4: ALU operation.
- `out_quarter` out 2: quarter select.
- `out_reg2mem` out 2: store byte-lane select.
- `halted` out 1: high in the HALTED state.
- `illegal` out 1: one-cycle pulse when an undefined opcode is accepted.
- `instr_count`, `branch_count` out CNT_W: present only with `DECODE_PERF_CNT_EN`.

## Operation
- **Accept rule.** Accept when `in_valid & in_ready`. `in_ready = (state!=HALTED) & (state!=HALT_PEND) & (~out_valid | out_ready)`.
- **Decode.** Combinational from `in_instr`, registered on accept.
- **Fully specified fields.** Every field has a defined value. Fields an opcode does not use drive 0; there are no X values.
- **Special register addresses:** ADR=4, MATH=5, CNT=7. `op[a:b]` below means operand bits, zero-extended to REG_AW.
- **Opcode 0–1 (add, sub).** rs0=op[3:2], rs1=MATH, wr=op[1:0], we=1. aluop 0 for add, 1 for sub.
- **Opcodes 2–4, 7–9, 12–13 (moves).** move=1, we=1.
  - Source/destination pairs: 2 = op[3:2]→op[1:0]; 3 = op[3:2]→ADR; 4 = ADR→op[1:0]; 7 = MATH→op[1:0]; 8 = op[3:2]→MATH; 9 = MATH→ADR; 12 = CNT→op[1:0]; 13 = op[3:2]→CNT.
  - Opcode 9 also sets quarter=op[3:2].
- **Opcodes 10–11 (quarter moves).** move=1, we=1, quarter=op[3:2]. 10: rs0=MATH, wr=op[1:0]. 11: rs0=op[1:0], wr=CNT.
- **Opcodes 5, 6, 14, 25 (immediate writes).** imm=1, we=1. 5: wr=ADR, jump_sign=op[0]. 6: rs0=operand, wr=MATH. 14: wr=CNT. 25: wr=op[1:0].
- **Opcodes 15–19 (conditional branches).** branch=1, rs0=op[3:2], rs1=op[1:0]. aluop: be 7, bne 8, bez 6, bltz 5, bgte 4.
- **Opcode 24 (jump).** branch=1, rs0=rs1=0, aluop=7.
- **Opcodes 20–21 (evu, evl).** we=1, rs0=op[3:2], wr=op[1:0]. aluop 2 for evu, 3 for evl.
- **Opcode 22 (ld).** we=1, mem2reg=1, rs0=op[3:2], rs1=ADR, wr=op[1:0].
- **Opcode 23 (st).** memwr=1, rs0=op[3:2], rs1=ADR, reg2mem=op[1:0].
- **Opcode 26 (halt).** start=1; all other fields 0.
- **Opcodes ≥27.** All-zero bundle, still emitted with out_valid. `illegal` pulses on the accept cycle +1.
- **FSM states:** RUN, HALT_PEND, HALTED.
  - RUN → HALT_PEND when a halt instruction is accepted.
  - HALT_PEND → HALTED when the halt bundle completes (`out_valid & out_ready`).
  - HALT_PEND → RUN on `flush`; the halt was wrong-path and is discarded.
  - HALTED is left only by reset.
- **Flush.** Clears out_valid next cycle and drops any same-cycle accept. In RUN and HALT_PEND it takes priority over accept and completion. In HALTED it has no effect.

## Timing
- **Latency.** 1 cycle from accept to out_valid. Full throughput (one instruction/cycle) when out_ready is held high.
- **Stability.** out_* is held stable while `out_valid & ~out_ready`.
- **Reset values.** Every output is 0 except `in_ready`, which is 1 after reset. State=RUN. Counters=0.
- **Reset mid-operation.** An asynchronous assert clears out_valid immediately. No bundle survives.
- **Simultaneous events.** Completion and a new accept in the same cycle: the new bundle replaces the old one with no bubble.

## Configuration
- **`DECODE_PERF_CNT_EN` defined:**
  - `instr_count` increments on each completed non-illegal bundle.
  - `branch_count` increments on each completed bundle with branch=1.
  - Both wrap modulo 2^CNT_W and are cleared by reset.
- **Not defined:** the ports and registers are absent.

## Structure
- **Package `cpu_pkg`:**
  - opcode enum (5-bit values 0–26);
  - ALU-op localparams (ADD=0 … NE=8);
  - special-register constants ADR/MATH/CNT;
  - packed struct `ctrl_bundle_t` holding all out_* fields.
- **Sub-module `decode_lut`:** purely combinational, `in_instr` → `ctrl_bundle_t` + illegal. `decode_stage` holds the register, handshake, FSM and counters.

## Test plan
- **Reset:** rst_n low then high → all outputs 0 except in_ready=1; halted=0.
- **add:** `in_instr=9'b00000_1001`, out_ready=1 → next cycle out_valid=1, rs0=2, rs1=5, wr=1, we=1, aluop=0.
- **Backpressure:** st `9'b10111_1110` with out_ready=0 for 3 cycles → bundle held (memwr=1, rs1=4, reg2mem=2), in_ready=0, no second accept.
- **Halt:** halt `9'b11010_0000` → state HALT_PEND, in_ready=0; after the bundle completes → halted=1, in_ready stays 0 for 10 cycles.
- **Flush:** flush in HALT_PEND → state RUN, out_valid=0, next valid instruction accepted.
- **Illegal/perf:** opcode 27 → one-cycle illegal pulse, zero bundle. With `DECODE_PERF_CNT_EN`, 4 adds + 2 be → instr_count=6, branch_count=2.
